// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one FP64 multiplier between NREQ requesters, with a
// fixed-latency tag pipe for result return and a drain/halt sequence. Optional stats: FPU_MUL_ARB_STATS_EN.
module fpu_mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned TAGW    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [64*NREQ-1:0]     req_srca,
    input  logic [64*NREQ-1:0]     req_srcb,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [63:0]            rsp_data,
    output logic                   mul_enable,
    output logic [63:0]            mul_srca,
    output logic [63:0]            mul_srcb,
    input  logic [63:0]            mul_dst,
    input  logic                   drain_req,
    output logic                   drained,
    output logic                   busy
`ifdef FPU_MUL_ARB_STATS_EN
    ,
    output logic [31:0]            stat_issue,
    output logic [31:0]            stat_stall
`endif
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [TAGW-1:0]   ptr;
    logic [NREQ-1:0]   grant;
    logic [TAGW-1:0]   gidx;
    logic              found;
    logic [63:0]       sel_a;
    logic [63:0]       sel_b;

    logic [TAGW-1:0]   iss_tag;
    logic [MUL_LAT-1:0] tp_v;
    logic [TAGW-1:0]   tp_t [MUL_LAT];

    // Two passes give "first valid at or after ptr, wrapping" without a modulo.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sel_a = '0;
        sel_b = '0;
        if (state == S_RUN && !drain_req) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && req_valid[j] && j >= 32'(ptr)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    gidx     = TAGW'(j);
                    sel_a    = req_srca[64*j +: 64];
                    sel_b    = req_srcb[64*j +: 64];
                end
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && req_valid[j] && j < 32'(ptr)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    gidx     = TAGW'(j);
                    sel_a    = req_srca[64*j +: 64];
                    sel_b    = req_srcb[64*j +: 64];
                end
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_enable <= 1'b0;
            mul_srca   <= '0;
            mul_srcb   <= '0;
            iss_tag    <= '0;
            ptr        <= '0;
        end else begin
            mul_enable <= found;
            if (found) begin
                mul_srca <= sel_a;
                mul_srcb <= sel_b;
                iss_tag  <= gidx;
                ptr      <= (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    // The issue register is the cycle before the multiplier; the tag pipe mirrors its MUL_LAT stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tp_v <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tp_t[i] <= '0;
            end
        end else begin
            tp_v[0] <= mul_enable;
            tp_t[0] <= iss_tag;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                tp_v[i] <= tp_v[i-1];
                tp_t[i] <= tp_t[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tp_v[MUL_LAT-1]) begin
            rsp_data = mul_dst;
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (tp_t[MUL_LAT-1] == TAGW'(j)) begin
                    rsp_valid[j] = 1'b1;
                end
            end
        end
    end

    assign busy = mul_enable | (|tp_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (drain_req) state_nxt = S_DRAIN;
            S_DRAIN: if (!busy)     state_nxt = S_HALT;
            S_HALT:  if (!drain_req) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    assign drained = (state == S_HALT);

`ifdef FPU_MUL_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (found && stat_issue != '1) begin
                stat_issue <= stat_issue + 32'd1;
            end
            if ((|(req_valid & ~grant)) && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter: a behavioural arbitration/drain model predicts grants
// and queues expected results; a monitor pops and compares every returned result.
module tb_fpu_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int TAGW    = 3;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_srca, req_srcb;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [63:0]          rsp_data, mul_srca, mul_srcb, mul_dst;
    logic                 mul_enable, drain_req, drained, busy;
`ifdef FPU_MUL_ARB_STATS_EN
    logic [31:0]          stat_issue, stat_stall;
`endif

    fpu_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_srca(req_srca), .req_srcb(req_srcb),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mul_enable(mul_enable),
        .mul_srca(mul_srca), .mul_srcb(mul_srcb), .mul_dst(mul_dst), .drain_req(drain_req),
        .drained(drained), .busy(busy)
`ifdef FPU_MUL_ARB_STATS_EN
        , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rnd_op();
        int v;
        v = int'($urandom_range(0, 2000));
        return $realtobits(($itor(v) - 1000.0) / 8.0);
    endfunction

    // Behavioural pipelined multiplier: result appears MUL_LAT cycles after the issue edge.
    logic [63:0] mp [MUL_LAT];
    always @(posedge clk) begin
        mp[0] <= mul_enable ? fmul(mul_srca, mul_srcb) : 64'hDEAD_BEEF_0BAD_F00D;
        for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_dst = mp[MUL_LAT-1];

    typedef struct {
        int          req;
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: pop one expected result whenever the DUT presents one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected cycle %0d: got rsp_valid %b expected none", cyc, rsp_valid);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.req);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    end
                end else begin
                    chk("rsp_data_idle", rsp_data, 64'd0);
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        e = sb.pop_front();
                        checks++; errors++;
                        $display("FAIL rsp_missing cycle %0d: got none expected req %0d due %0d", cyc, e.req, e.due);
                    end
                end
            end
        end
    end

    // Driver-side stimulus state and reference model.
    logic [NREQ-1:0] nv;
    logic [63:0]     na [NREQ];
    logic [63:0]     nb [NREQ];
    logic            nd, nr;
    int mode, mptr, last_acc, m_issue, m_stall, mgrant;

    task automatic rnd_fill(input int i);
        na[i] = rnd_op();
        nb[i] = rnd_op();
    endtask

    task automatic apply();
        req_valid = nv;
        for (int i = 0; i < NREQ; i++) begin
            req_srca[64*i +: 64] = na[i];
            req_srcb[64*i +: 64] = nb[i];
        end
        drain_req = nd;
        rst_n = nr;
    endtask

    task automatic tick();
        bit bsy;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        apply();
        #1;
        if (!nr) begin
            sb.delete();
            mode = M_RUN; mptr = 0; last_acc = -1000; m_issue = 0; m_stall = 0; mgrant = -1;
            return;
        end
        bsy = (cyc - last_acc) <= (MUL_LAT + 1);
        chk("busy", 64'(busy), 64'(bsy));
        chk("drained", 64'(drained), 64'(mode == M_HALT));
`ifdef FPU_MUL_ARB_STATS_EN
        chk("stat_issue", 64'(stat_issue), 64'(m_issue));
        chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
        mgrant = -1;
        if (mode == M_RUN && !nd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mgrant < 0 && nv[(mptr + i) % NREQ]) mgrant = (mptr + i) % NREQ;
            end
        end
        exp_ready = '0;
        if (mgrant >= 0) exp_ready[mgrant] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (mgrant >= 0) begin
            sb.push_back('{req: mgrant, data: fmul(na[mgrant], nb[mgrant]), due: cyc + 1 + MUL_LAT});
            mptr = (mgrant + 1) % NREQ;
            last_acc = cyc;
            m_issue++;
        end
        if ((nv & ~exp_ready) != '0) m_stall++;
        case (mode)
            M_RUN:   if (nd) mode = M_DRAIN;
            M_DRAIN: if (!bsy) mode = M_HALT;
            default: if (!nd) mode = M_RUN;
        endcase
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mul_enable"}, 64'(mul_enable), 64'd0);
        chk({tag, "_mul_srca"}, mul_srca, 64'd0);
        chk({tag, "_mul_srcb"}, mul_srcb, 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_drained"}, 64'(drained), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
`ifdef FPU_MUL_ARB_STATS_EN
        chk({tag, "_stat_issue"}, 64'(stat_issue), 64'd0);
        chk({tag, "_stat_stall"}, 64'(stat_stall), 64'd0);
`endif
    endtask

    task automatic do_reset();
        nv = '0; nd = 1'b0; nr = 1'b0;
        tick();
        nr = 1'b1;
    endtask

    task automatic idle(input int n);
        nv = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int fall, done, saw_halt;
        nv = '0; nd = 1'b0; nr = 1'b0;
        for (int i = 0; i < NREQ; i++) rnd_fill(i);
        apply();
        tick(); tick();
        mon_en = 1'b1;
        nr = 1'b1;

        // Reset state
        tick();
        check_zero("reset");

        // Single op: 2.0 * 3.0 = 6.0, three cycles after accept
        na[0] = 64'h4000000000000000; nb[0] = 64'h4008000000000000;
        nv = 4'b0001;
        tick();
        nv = '0;
        tick(); tick();
        chk("single_early", 64'(rsp_valid), 64'd0);
        tick();
        chk("single_vld", 64'(rsp_valid), 64'b0001);
        chk("single_data", rsp_data, 64'h4018000000000000);
        idle(3);

        // Round-robin with all requesters held valid
        do_reset(); tick();
        nv = '1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_grant", 64'(req_ready), 64'(1) << (i % NREQ));
            if (mgrant >= 0) rnd_fill(mgrant);
`ifdef FPU_MUL_ARB_STATS_EN
            if (i == 4) begin
                chk("stats_issue4", 64'(stat_issue), 64'd4);
                chk("stats_stall4", 64'(stat_stall), 64'd4);
            end
`endif
        end
        idle(6);

        // Sparse fairness: pointer moved to 2, then only 0 and 3 valid
        do_reset();
        nv = 4'b0010; tick();
        nv = 4'b1001; tick();
        chk("sparse_first", 64'(req_ready), 64'b1000);
        nv = 4'b0001; tick();
        chk("sparse_second", 64'(req_ready), 64'b0001);
        idle(6);

        // Drain with three ops in flight, requesters still asserting
        nv = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mgrant >= 0) rnd_fill(mgrant);
        end
        nd = 1'b1;
        fall = -1; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            chk("drain_no_grant", 64'(req_ready), 64'd0);
            if (!busy && fall < 0) fall = cyc;
            if (drained) begin
                chk("drain_when", 64'(cyc), 64'(fall + 1));
                chk("drain_all_returned", 64'(sb.size()), 64'd0);
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout cycle %0d: got drained=0 expected drained=1 within 20 cycles", cyc);
        end
        tick(); tick();
        nd = 1'b0;
        tick();
        chk("resume_still_halted", 64'(drained), 64'd1);
        tick();
        chk("resume_drained", 64'(drained), 64'd0);
        chk("resume_grant", 64'(req_ready != '0), 64'd1);
        idle(6);

        // Short drain pulse: must still pass through HALT
        nv = 4'b0100; tick();
        nv = '0; nd = 1'b1; tick();
        nd = 1'b0; saw_halt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drained) saw_halt = 1;
        end
        chk("pulse_halt", 64'(saw_halt), 64'd1);
        chk("pulse_back_run", 64'(drained), 64'd0);

        // Reset with two ops in flight
        nv = '1; tick(); tick();
        do_reset();
        tick();
        check_zero("midreset");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midreset_quiet", 64'(rsp_valid), 64'd0);
        end

        // Randomized traffic with occasional drain toggles
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!nv[r] && $urandom_range(0, 9) < 4) begin
                    rnd_fill(r);
                    nv[r] = 1'b1;
                end
            end
            if ($urandom_range(0, 39) == 0) nd = ~nd;
            tick();
            if (mgrant >= 0) begin
                rnd_fill(mgrant);
                nv[mgrant] = 1'($urandom_range(0, 1));
            end
        end
        nd = 1'b0;
        idle(12);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one FP64 multiplier between NREQ requesters (integer-side MUL, FMAC sequencer, divide/sqrt iteration unit, spare).
- Arbitrates round-robin and drives the multiplier's operand and enable lines.
- Tracks each issued operation through a fixed-latency tag pipeline and returns each result to the requester that issued it.
- Provides a drain/halt sequence so the core can quiesce the FPU before a context switch.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, cycles from the issue edge to a valid mul_dst (1..8).
- TAGW, 3, tag width; must satisfy 2^TAGW >= NREQ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester operation request.
- req_srca  in  64*NREQ  operand A; requester i uses bits [64i+63:64i].
- req_srcb  in  64*NREQ  operand B, same packing.
- req_ready  out  NREQ  one-hot grant; an operation is accepted when valid&ready in a cycle.
- rsp_valid  out  NREQ  one-hot result strobe, one cycle wide.
- rsp_data  out  64  result, shared by all requesters and qualified by rsp_valid.
- mul_enable  out  1  multiplier issue strobe.
- mul_srca  out  64  operand A to the multiplier.
- mul_srcb  out  64  operand B to the multiplier.
- mul_dst  in  64  multiplier result, valid MUL_LAT cycles after issue.
- drain_req  in  1  level input; request quiesce.
- drained  out  1  high while halted with the pipeline empty.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset: every output is 0; tag pipe is empty; round-robin pointer = 0; state = RUN. Reset in the middle of an operation discards in-flight ops and raises no rsp_valid afterwards.
- Arbitration (combinational):
  - Applies only in state RUN.
  - req_ready gets a single bit: the first asserted req_valid at or after the pointer, wrapping modulo NREQ.
  - If no request is asserted, req_ready = 0.
  - Requesters must not make req_ready a condition of req_valid.
- Issue (registered):
  - On an accepted grant to requester g, next cycle mul_enable=1 and mul_srca/mul_srcb carry g's operands.
  - The pointer advances to (g+1) mod NREQ.
  - The tag pipe stage 0 loads {valid=1, tag=g}.
  - With no grant, mul_enable=0 and the operand registers hold their last value.
  - Throughput: one issue per cycle.
- Tag pipe:
  - MUL_LAT stages, shifting every cycle.
  - When the last stage is valid, rsp_valid[tag]=1 and rsp_data=mul_dst in that same cycle.
  - End-to-end latency: the accept edge, then 1 + MUL_LAT cycles to rsp_valid.
  - The register stage before the multiplier adds 1 cycle.
  - rsp_data = 0 whenever no rsp_valid bit is set.
- busy = OR of the tag-pipe valid bits and the issue register.
- State machine:
  - RUN: grants enabled. If drain_req=1, go to DRAIN; the grant is suppressed in that same cycle.
  - DRAIN: grants off; in-flight results still return. When busy=0, go to HALT.
  - HALT: drained=1. When drain_req falls, go to RUN (drained=0 in that cycle); the grant resumes the following cycle.
  - If drain_req rises and falls before DRAIN completes, the drain still completes: HALT is entered and then RUN is re-entered one cycle later.
- Boundary cases:
  - All requesters asserting continuously: each is granted exactly once per NREQ cycles.
  - NREQ=1: the arbiter degenerates to a pass-through.
  - A requester may re-request while its previous result is still in flight; results return in issue order.

Optional Feature:
- Macro FPU_MUL_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_issue (32 bits), a count of issued ops.
  - Adds stat_stall (32 bits), a count of cycles in which some req_valid was high but no grant was given (contention or drain).
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: those ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single op: after reset, req 0 issues srca=0x4000000000000000, srcb=0x4008000000000000 with MUL_LAT=2 and a behavioural multiplier. Required: rsp_valid=4'b0001 exactly 3 cycles after accept, rsp_data=0x4018000000000000.
- Round-robin: all four requesters hold valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; each rsp_valid arrives 3 cycles after its grant with that requester's product.
- Sparse fairness: pointer=2, only requesters 0 and 3 valid. Required: grant goes to 3 first, then 0.
- Drain: 3 ops in flight when drain_req rises. Required: no new grants; all 3 results delivered; drained=1 in the cycle after busy falls. After drain_req=0: drained=0 and the grant resumes the next cycle.
- Reset mid-flight: rst_n=0 for 1 cycle with 2 ops in flight. Required: no rsp_valid in the following 10 cycles; all outputs 0.
- With FPU_MUL_ARB_STATS_EN: 4 requesters contend for 4 cycles. Required: stat_issue=4 and stat_stall=4.
